// File: rtl/nic8_pkg.sv
// Shared nic8 definitions: instruction-cycle phase encoding and the
// default width of the retired-instruction counter.
package nic8_pkg;

  localparam int INSTR_COUNT_W = 16;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } phase_t;

endpackage

// File: rtl/phase_sequencer_if.sv
// Front-panel / decoder bundle around phase_sequencer. The master modport is
// the sequencer; the slave modport is the panel+decoder side.
interface phase_sequencer_if
  import nic8_pkg::*;
#(
  parameter int COUNT_W = INSTR_COUNT_W
);
  logic               runReq;
  logic               stepReq;
  logic [7:0]         pc;
  logic [7:0]         breakAddr;
  logic               breakEnable;
  logic               irLoadBar;
  logic               execEnable;
  logic               halted;
  logic               breakHit;
  logic [COUNT_W-1:0] instrCount;
  phase_t             phase;      // debug view of the sequencer state

  modport master (
    input  runReq, stepReq, pc, breakAddr, breakEnable,
    output irLoadBar, execEnable, halted, breakHit, instrCount, phase
  );

  modport slave (
    output runReq, stepReq, pc, breakAddr, breakEnable,
    input  irLoadBar, execEnable, halted, breakHit, instrCount, phase
  );
endinterface

// File: rtl/step_edge.sv
// Rising-edge detector for a synchronous front-panel button level.
// The history register resets high so a button held through reset is not an edge.
module step_edge (
  input  logic clk,
  input  logic resetBar,
  input  logic level,
  output logic rise
);
  logic prevLevel;

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) prevLevel <= 1'b1;
    else           prevLevel <= level;
  end

  assign rise = level & ~prevLevel;
endmodule

// File: rtl/phase_sequencer.sv
// nic8 two-phase (FETCH/EXEC) sequencer with run, halt and single-step control.
// Optional PC breakpoint is built when PHASE_SEQ_BREAKPOINT_EN is defined.
module phase_sequencer
  import nic8_pkg::*;
#(
  parameter int COUNT_W = INSTR_COUNT_W
) (
  input  logic               clk,
  input  logic               resetBar,
  phase_sequencer_if.master  bus
);
  phase_t             state, nextState;
  logic               stepMode, nextStepMode;
  logic               stepEdge;
  logic               breakMatch;
  logic               breakHitQ;
  logic [COUNT_W-1:0] countQ;

  step_edge uStepEdge (
    .clk      (clk),
    .resetBar (resetBar),
    .level    (bus.stepReq),
    .rise     (stepEdge)
  );

`ifdef PHASE_SEQ_BREAKPOINT_EN
  assign breakMatch = bus.breakEnable & (bus.pc == bus.breakAddr);

  // Set only on a run-mode EXEC that halts because of the match; a step
  // request or a dropped run level in HALT acknowledges it.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      breakHitQ <= 1'b0;
    end else if (state == HALT && (stepEdge || !bus.runReq)) begin
      breakHitQ <= 1'b0;
    end else if (state == EXEC && !stepMode && bus.runReq && breakMatch) begin
      breakHitQ <= 1'b1;
    end
  end
`else
  logic unusedBreakInputs;
  assign unusedBreakInputs = ^{bus.pc, bus.breakAddr, bus.breakEnable};
  assign breakMatch        = 1'b0;
  assign breakHitQ         = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state    <= HALT;
      stepMode <= 1'b0;
    end else begin
      state    <= nextState;
      stepMode <= nextStepMode;
    end
  end

  always_comb begin
    nextState    = state;
    nextStepMode = stepMode;
    case (state)
      HALT: begin
        // Step wins over run when both arrive together.
        if (stepEdge) begin
          nextState    = FETCH;
          nextStepMode = 1'b1;
        end else if (bus.runReq && !breakHitQ) begin
          nextState    = FETCH;
          nextStepMode = 1'b0;
        end
      end
      FETCH: nextState = EXEC;
      EXEC: begin
        if (stepMode)         nextState = HALT;
        else if (!bus.runReq) nextState = HALT;
        else if (breakMatch)  nextState = HALT;
        else                  nextState = FETCH;
      end
      default: nextState = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar)          countQ <= '0;
    else if (state == EXEC) countQ <= countQ + COUNT_W'(1);
  end

  assign bus.irLoadBar  = (state != FETCH);
  assign bus.execEnable = (state == EXEC);
  assign bus.halted     = (state == HALT);
  assign bus.breakHit   = breakHitQ;
  assign bus.instrCount = countQ;
  assign bus.phase      = state;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (COUNT_W=4); covers the breakpoint path
// when PHASE_SEQ_BREAKPOINT_EN is defined and its absence otherwise.
module tb_phase_sequencer;
  import nic8_pkg::*;

  logic clk;
  logic resetBar;
  int   testsRun;
  int   testsFailed;

  phase_sequencer_if #(.COUNT_W(4)) bus ();

  phase_sequencer #(.COUNT_W(4)) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetBar        = 1'b0;
    bus.runReq      = 1'b0;
    bus.stepReq     = 1'b1;
    bus.pc          = 8'h00;
    bus.breakAddr   = 8'h00;
    bus.breakEnable = 1'b0;

    // Reset with the step button held
    tick(); tick();
    check("rst_halted", 16'(bus.halted), 16'd1);
    check("rst_irLoadBar", 16'(bus.irLoadBar), 16'd1);
    check("rst_execEnable", 16'(bus.execEnable), 16'd0);
    check("rst_breakHit", 16'(bus.breakHit), 16'd0);
    check("rst_count", 16'(bus.instrCount), 16'd0);
    check("rst_phase", 16'(bus.phase), 16'(HALT));
    resetBar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("held_halted", 16'(bus.halted), 16'd1);
      check("held_irLoadBar", 16'(bus.irLoadBar), 16'd1);
      check("held_count", 16'(bus.instrCount), 16'd0);
    end

    // Single step; a second edge during that instruction is not queued
    bus.stepReq = 1'b0; tick();
    check("step_idle", 16'(bus.halted), 16'd1);
    bus.stepReq = 1'b1; tick();
    check("step_fetch", 16'(bus.irLoadBar), 16'd0);
    check("step_fetch_noexec", 16'(bus.execEnable), 16'd0);
    bus.stepReq = 1'b0; tick();
    check("step_exec", 16'(bus.execEnable), 16'd1);
    bus.stepReq = 1'b1; tick();
    check("step_halt", 16'(bus.halted), 16'd1);
    check("step_count", 16'(bus.instrCount), 16'd1);
    tick();
    check("step_not_queued", 16'(bus.halted), 16'd1);
    check("step_count_hold", 16'(bus.instrCount), 16'd1);
    bus.stepReq = 1'b0;

    // Run for 10 cycles then drop run
    bus.runReq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("run_irLoadBar", 16'(bus.irLoadBar), (i % 2 == 1) ? 16'd0 : 16'd1);
      check("run_execEnable", 16'(bus.execEnable), (i % 2 == 0) ? 16'd1 : 16'd0);
    end
    bus.runReq = 1'b0; tick();
    check("run_halted", 16'(bus.halted), 16'd1);
    check("run_count", 16'(bus.instrCount), 16'd6);

    // Run dropped during FETCH still completes EXEC
    bus.runReq = 1'b1; tick();
    check("drop_fetch", 16'(bus.irLoadBar), 16'd0);
    bus.runReq = 1'b0; tick();
    check("drop_exec", 16'(bus.execEnable), 16'd1);
    tick();
    check("drop_halted", 16'(bus.halted), 16'd1);
    check("drop_count", 16'(bus.instrCount), 16'd7);

    // Step and run together: one instruction then HALT
    bus.runReq = 1'b1; bus.stepReq = 1'b1; tick();
    check("both_fetch", 16'(bus.irLoadBar), 16'd0);
    tick();
    check("both_exec", 16'(bus.execEnable), 16'd1);
    tick();
    check("both_halted", 16'(bus.halted), 16'd1);
    check("both_count", 16'(bus.instrCount), 16'd8);
    bus.runReq = 1'b0; bus.stepReq = 1'b0; tick();
    check("both_stay", 16'(bus.halted), 16'd1);

    // Breakpoint at 0x03
    bus.breakEnable = 1'b1; bus.breakAddr = 8'h03; bus.runReq = 1'b1;
    tick();                       // FETCH
    tick(); bus.pc = 8'h01;       // EXEC
    tick();                       // FETCH
    tick(); bus.pc = 8'h02;       // EXEC
    tick();                       // FETCH
    tick(); bus.pc = 8'h03;       // EXEC, matching pc
    check("bp_exec3", 16'(bus.execEnable), 16'd1);
    tick();
`ifdef PHASE_SEQ_BREAKPOINT_EN
    check("bp_halted", 16'(bus.halted), 16'd1);
    check("bp_hit", 16'(bus.breakHit), 16'd1);
    check("bp_count", 16'(bus.instrCount), 16'd11);
    tick(); tick();
    check("bp_hold_halted", 16'(bus.halted), 16'd1);
    check("bp_hold_hit", 16'(bus.breakHit), 16'd1);
    bus.runReq = 1'b0; bus.pc = 8'h10; tick();
    check("bp_clear_hit", 16'(bus.breakHit), 16'd0);
    check("bp_clear_halted", 16'(bus.halted), 16'd1);
    bus.runReq = 1'b1; tick();
    check("bp_resume", 16'(bus.irLoadBar), 16'd0);
`else
    check("nobp_running", 16'(bus.halted), 16'd0);
    check("nobp_fetch", 16'(bus.irLoadBar), 16'd0);
    check("nobp_hit", 16'(bus.breakHit), 16'd0);
`endif
    bus.runReq = 1'b0; tick();
    check("bp_final_exec", 16'(bus.execEnable), 16'd1);
    tick();
    check("bp_final_halted", 16'(bus.halted), 16'd1);
    check("bp_final_count", 16'(bus.instrCount), 16'd12);
    bus.breakEnable = 1'b0;

    // Count wrap over 17 instructions
    resetBar = 1'b0; #1;
    check("wrap_rst_count", 16'(bus.instrCount), 16'd0);
    resetBar = 1'b1; tick();
    bus.runReq = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i == 31) check("wrap_count15", 16'(bus.instrCount), 16'd15);
      if (i == 33) check("wrap_count0", 16'(bus.instrCount), 16'd0);
    end
    bus.runReq = 1'b0; tick();
    check("wrap_halted", 16'(bus.halted), 16'd1);
    check("wrap_count1", 16'(bus.instrCount), 16'd1);

    // Asynchronous reset during EXEC
    bus.runReq = 1'b1; tick(); tick();
    check("midrst_exec", 16'(bus.execEnable), 16'd1);
    #2 resetBar = 1'b0; #1;
    check("midrst_halted", 16'(bus.halted), 16'd1);
    check("midrst_execEnable", 16'(bus.execEnable), 16'd0);
    check("midrst_irLoadBar", 16'(bus.irLoadBar), 16'd1);
    check("midrst_count", 16'(bus.instrCount), 16'd0);
    bus.runReq = 1'b0;
    tick();
    resetBar = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Sequences the nic8 CPU's two-phase instruction cycle (FETCH then EXEC) and provides front-panel run, halt and single-step control with an optional PC breakpoint.

- It sits between the system clock and the instruction decoder.
- `irLoadBar` qualifies the IR load and ROM fetch.
- `execEnable` qualifies the decoder's register triggers, memory store and PC load.
- It also counts retired instructions for debug.

## Interface
- `COUNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetBar`  in  1  reset; asynchronous, active-low.
- `runReq`  in  1  level; 1 requests free-running execution. Synchronous to `clk`; synchronised externally.
- `stepReq`  in  1  level from the step button; a rising edge requests one instruction. Synchronous to `clk`.
- `pc`  in  8  current program counter; during EXEC it holds the address of the next fetch.
- `breakAddr`  in  8  breakpoint address.
- `breakEnable`  in  1  1 arms the breakpoint.
- `irLoadBar`  out  1  active-low; 0 exactly during FETCH cycles.
- `execEnable`  out  1  1 exactly during EXEC cycles.
- `halted`  out  1  1 in HALT.
- `breakHit`  out  1  sticky; 1 after a breakpoint stop.
- `instrCount`  out  COUNT_W  number of completed EXEC cycles; wraps.

## Operation
- States: HALT, FETCH, EXEC. Outputs are Moore-decoded from state, except `breakHit` and `instrCount`, which are registers.
- Internal registers:
  - `stepMode` (1 bit).
  - `stepPrev`, which holds last cycle's `stepReq`.
  - `stepEdge = stepReq & ~stepPrev`.
- HALT transitions:
  - If `stepEdge`: go to FETCH, `stepMode`=1, clear `breakHit`.
  - Else if `runReq` & ~`breakHit`: go to FETCH, `stepMode`=0.
  - Otherwise stay in HALT.
  - If `runReq`=0 while in HALT, clear `breakHit`. The user re-arms run by dropping `runReq` and raising it again.
- FETCH: unconditionally go to EXEC.
- EXEC: `instrCount` increments by 1, modulo 2^COUNT_W. The next state is the first rule that applies:
  1. `stepMode`=1: go to HALT.
  2. `runReq`=0: go to HALT.
  3. `breakEnable` & (`pc`==`breakAddr`): go to HALT and set `breakHit`.
  4. Otherwise: go to FETCH.
- `breakHit` is never set on a step-mode EXEC, because rule 1 takes precedence.
- `stepEdge` outside HALT is ignored and is not queued. `stepPrev` still tracks `stepReq` every cycle.
- `runReq` dropping in FETCH does not abort the cycle. The instruction completes its EXEC, then the sequencer halts.

## Timing
- Reset, asynchronous and effective immediately, mid-instruction included:
  - state = HALT, `stepMode`=0, `stepPrev`=1.
  - Outputs: `irLoadBar`=1, `execEnable`=0, `halted`=1, `breakHit`=0, `instrCount`=0.
- Because `stepPrev` resets to 1, a step button held through reset produces no step.
- `runReq` rising in HALT: FETCH on the next cycle, then strictly alternating FETCH/EXEC, 2 clocks per instruction.
- `stepEdge` seen in HALT at edge N:
  - FETCH in cycle N+1, EXEC in N+2, HALT from N+3.
  - `instrCount` increments at the end of N+2.
- Breakpoint compare uses `pc` sampled at the EXEC clock edge. `halted` rises on the following cycle, and no further FETCH occurs.
- `instrCount` wraps from all-ones to 0 without any flag.
- If `stepEdge` and `runReq` are true in HALT in the same cycle, step wins: exactly one instruction runs, then HALT.

## Configuration
- `PHASE_SEQ_BREAKPOINT_EN`:
  - Defined: the comparator and the `breakHit` register are built, and EXEC rule 3 is active.
  - Undefined: the ports remain, but `breakAddr` and `breakEnable` are ignored, `breakHit` is tied to 0, and rule 3 is absent.

## Structure
- Shared package `nic8_pkg`:
  - Phase state typedef (HALT, FETCH, EXEC, 2-bit encoding).
  - `INSTR_COUNT_W` constant = 16, used as the COUNT_W default.
- One sub-module, `step_edge`:
  - Contains the `stepPrev` register, reset to 1, and the rising-edge output.
  - Reused later for other front-panel buttons.

## Test plan
- **Reset with step held:** hold `resetBar`=0 with `stepReq`=1, release it, keep `stepReq`=1 for 5 cycles, `runReq`=0.
  - Required: `halted`=1, `irLoadBar`=1, `instrCount`=0 throughout.
- **Single step:** in HALT, pulse `stepReq` 0→1.
  - Required: one FETCH cycle (`irLoadBar`=0), one EXEC cycle (`execEnable`=1), then `halted`=1 and `instrCount`=1.
  - Required: a second `stepReq` rising edge while in FETCH is ignored.
- **Run, then drop run:** raise `runReq` for 10 cycles, then drop it.
  - Required: FETCH/EXEC strictly alternate; `instrCount`=5 when `halted` returns.
  - Required: a drop during FETCH still completes that instruction's EXEC.
- **Breakpoint (macro defined):** `breakEnable`=1, `breakAddr`=0x03, `pc` supplied as 0x01, 0x02, 0x03 in successive EXEC cycles, `runReq`=1.
  - Required: HALT after the third EXEC with `breakHit`=1.
  - Required: holding `runReq`=1 keeps HALT; dropping `runReq` clears `breakHit`; raising it again resumes.
- **Count wrap, and reset mid-run:** with COUNT_W=4, run 17 instructions.
  - Required: `instrCount`=1 after the 17th.
  - Then assert `resetBar`=0 during an EXEC. Required: immediately `halted`=1, `execEnable`=0, `instrCount`=0.
